// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and types for the two-level carry-lookahead adder
// Contents: GROUP (bits per lookahead group), CLA_WIDTH/NGROUPS (default datapath size),
//           gp_t (group generate/propagate pair).
package cla_pkg;

    localparam int GROUP     = 4;
    localparam int CLA_WIDTH = 32;
    localparam int NGROUPS   = CLA_WIDTH / GROUP;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

endpackage

// File: rtl/cla_4b.sv
// rtl/cla_4b.sv - 4-bit carry-lookahead group
// Ports: a, b   - 4-bit operand slices
//        cin    - carry into bit 0 of the group (from the second-level unit)
//        sum    - 4-bit sum slice
//        gp     - group generate/propagate, independent of cin
module cla_4b
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output gp_t        gp
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every internal carry is a flat sum of products of g/p and cin; no bit waits on its neighbour.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    // Group terms deliberately exclude cin so the second level can use them before any carry exists.
    assign gp.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gp.p = &p;

    assign sum = p ^ c;

endmodule

// File: rtl/cla_32bits.sv
// rtl/cla_32bits.sv - 32-bit two-level carry-lookahead adder with registered copy
// Ports: clk        - clock for the registered outputs only
//        rst        - asynchronous active-high reset of the registered outputs
//        a, b, ci   - unsigned operands and carry in
//        s, co      - combinational {co, s} = a + b + ci
//        s_q, co_q  - s and co registered one cycle later
//        ovf, ovf_q - signed overflow and its registered copy (only with CLA_32BITS_OVF_EN)
module cla_32bits
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic [WIDTH-1:0] s_q,
    output logic             co_q
`ifdef CLA_32BITS_OVF_EN
    ,
    output logic             ovf,
    output logic             ovf_q
`endif
);

    // WIDTH must be a multiple of GROUP; the remainder bits would otherwise be left undriven.
    localparam int NG = WIDTH / GROUP;

    gp_t          grp [NG];
    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;
    logic [NG:0]   gc;

    // Second-level lookahead: c[4(k+1)] is built as an OR of independent product terms
    // (ci and each group generate, each ANDed with the propagates above it) so the
    // depth stays two levels of logic rather than a chain through the groups.
    function automatic logic [NG:0] lookahead(
        input logic [NG-1:0] gg,
        input logic [NG-1:0] pp,
        input logic          cin
    );
        logic [NG:0] c;
        logic        term;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < NG; k++) begin
            term = cin;
            for (int m = 0; m <= k; m++) begin
                term = term & pp[m];
            end
            c[k+1] = term;
            for (int j = 0; j <= k; j++) begin
                term = gg[j];
                for (int m = j + 1; m <= k; m++) begin
                    term = term & pp[m];
                end
                c[k+1] = c[k+1] | term;
            end
        end
        return c;
    endfunction

    genvar k;
    generate
        for (k = 0; k < NG; k++) begin : g_grp
            cla_4b u_grp (
                .a   (a[GROUP*k +: GROUP]),
                .b   (b[GROUP*k +: GROUP]),
                .cin (gc[k]),
                .sum (s[GROUP*k +: GROUP]),
                .gp  (grp[k])
            );
            assign grp_g[k] = grp[k].g;
            assign grp_p[k] = grp[k].p;
        end
    endgenerate

    assign gc = lookahead(grp_g, grp_p, ci);
    assign co = gc[NG];

`ifdef CLA_32BITS_OVF_EN
    // The msb sum is p ^ c, so the carry into the msb is recovered as s ^ a ^ b there
    // without exporting an extra carry from the top group.
    assign ovf = gc[NG] ^ s[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q  <= '0;
            co_q <= 1'b0;
        end else begin
            s_q  <= s;
            co_q <= co;
        end
    end

endmodule

// File: tb/tb_cla_32bits.sv
// tb/tb_cla_32bits.sv - scoreboard bench for cla_32bits
module tb_cla_32bits;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        clk_run;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] s;
    logic        co;
    logic [31:0] s_q;
    logic        co_q;
`ifdef CLA_32BITS_OVF_EN
    logic        ovf;
    logic        ovf_q;
`endif

    exp_t cq[$];
    exp_t rq[$];
    event ev_comb;

    int checks = 0;
    int errors = 0;

    cla_32bits #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .s     (s),
        .co    (co),
        .s_q   (s_q),
        .co_q  (co_q)
`ifdef CLA_32BITS_OVF_EN
        ,
        .ovf   (ovf),
        .ovf_q (ovf_q)
`endif
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (a=%h b=%h ci=%b)", name, act, exp, a, b, ci);
        end
    endtask

    // Comb monitor: one expected entry per issued vector.
    initial begin
        exp_t e;
        forever begin
            @(ev_comb);
            if (cq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL comb_underflow: got empty queue expected an entry");
            end else begin
                e = cq.pop_front();
                chk("comb_s", 64'(s), 64'(e.s));
                chk("comb_co", 64'(co), 64'(e.co));
`ifdef CLA_32BITS_OVF_EN
                chk("comb_ovf", 64'(ovf), 64'(e.ovf));
`endif
            end
        end
    end

    // Registered monitor: entries are pushed before the edge that should capture them.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rq.size() > 0) begin
                e = rq.pop_front();
                chk("reg_s_q", 64'(s_q), 64'(e.s));
                chk("reg_co_q", 64'(co_q), 64'(e.co));
`ifdef CLA_32BITS_OVF_EN
                chk("reg_ovf_q", 64'(ovf_q), 64'(e.ovf));
`endif
            end
        end
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                         input exp_t e, input bit to_reg);
        a  = va;
        b  = vb;
        ci = vc;
        #1;
        cq.push_back(e);
        if (to_reg) rq.push_back(e);
        ->ev_comb;
        #1;
    endtask

    function automatic exp_t ref_sum(input logic [31:0] va, input logic [31:0] vb, input logic vc);
        exp_t        e;
        logic [32:0] r;
        r     = {1'b0, va} + {1'b0, vb} + {32'b0, vc};
        e.s   = r[31:0];
        e.co  = r[32];
        e.ovf = (va[31] == vb[31]) && (r[31] != va[31]);
        return e;
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    vec_t dir[6];

    initial begin
        exp_t e;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;

        dir[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        dir[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        dir[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        dir[3] = '{32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0};
        dir[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        dir[5] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0};

        clk_run = 1'b0;
        rst = 1'b0;
        a = '0;
        b = '0;
        ci = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        chk("reset_s_q", 64'(s_q), 64'h0);
        chk("reset_co_q", 64'(co_q), 64'h0);

        for (int i = 0; i < 6; i++) begin
            e.s = dir[i].s;
            e.co = dir[i].co;
            e.ovf = dir[i].ovf;
            issue(dir[i].a, dir[i].b, dir[i].ci, e, 1'b0);
        end

        // Exhaustive low range with the clock parked.
        for (int i = 0; i < 1024; i++) begin
            for (int j = 0; j < 1024; j++) begin
                for (int c = 0; c < 2; c++) begin
                    e.s = 32'(i + j + c);
                    e.co = 1'b0;
                    e.ovf = 1'b0;
                    issue(32'(i), 32'(j), 1'(c), e, 1'b0);
                end
            end
        end

        clk_run = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Registered path: 0x12345678 + 0x11111111 + 1.
        @(negedge clk);
        e.s = 32'h2345_678A;
        e.co = 1'b0;
        e.ovf = 1'b0;
        issue(32'h1234_5678, 32'h1111_1111, 1'b1, e, 1'b1);

        // Asynchronous reset mid-cycle, with no edge between assert and check.
        @(posedge clk);
        #3;
        chk("pre_rst_s_q", 64'(s_q), 64'h2345_678A);
        rst = 1'b1;
        #1;
        chk("async_rst_s_q", 64'(s_q), 64'h0);
        chk("async_rst_co_q", 64'(co_q), 64'h0);
        @(posedge clk);
        #1;
        chk("held_rst_s_q", 64'(s_q), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("released_s_q", 64'(s_q), 64'h0);
        @(posedge clk);
        #1;
        chk("first_edge_s_q", 64'(s_q), 64'h2345_678A);
        chk("first_edge_co_q", 64'(co_q), 64'h0);

        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            issue(ra, rb, rc, ref_sum(ra, rb, rc), 1'b1);
        end

        @(posedge clk);
        #2;
        chk("comb_queue_drained", 64'(cq.size()), 64'h0);
        chk("reg_queue_drained", 64'(rq.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
